imem_ctrl: RTL and testbench
============================

# imem_ctrl

Instruction-memory controller between the fetch stage, an external program loader and the 1024-word instruction memory array. After reset it holds the core in reset and streams loader words into memory at auto-incrementing addresses. When the last word arrives it releases the core and serves fetch reads. Optionally, it arbitrates runtime patch writes against fetch by stalling the fetch stage.

## Interface
- `ADDR_W`, default 10: word-address width; memory depth is 2^ADDR_W words.
- `NOP_INSTR`, default 32'h00000013: instruction returned on stall, fault, or while the core is held.

Ports (`clk`, `rst` first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  loader word valid.
- `ld_ready`  out  1  loader word accepted when `ld_valid & ld_ready`.
- `ld_data`  in  32  loader word.
- `ld_addr`  in  32  byte address; used only for runtime patches; bits [1:0] ignored.
- `ld_last`  in  1  final boot word, qualified by `ld_valid`.
- `core_rst_n`  out  1  registered active-low reset to the pipeline.
- `fetch_pc`  in  32  fetch byte address.
- `fetch_instr`  out  32  instruction word.
- `fetch_stall`  out  1  fetch must hold its PC this cycle.
- `fetch_fault`  out  1  PC misaligned or out of range.
- `boot_cnt`  out  ADDR_W+1  number of words written during boot.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  combinational read data for `mem_addr`.

## Operation
- **States:** BOOT and RUN, state register only. Reset forces BOOT.
- **BOOT:**
  - `ld_ready`=1 and `mem_addr`=`boot_cnt`.
  - `mem_we` = `ld_valid`; `mem_wdata` = `ld_data`.
  - `boot_cnt` increments on each accepted word.
  - `fetch_stall`=1 and `fetch_instr`=`NOP_INSTR`.
- **BOOT→RUN:** on an accepted word with `ld_last`=1, or on the accepted word written at address 2^ADDR_W−1 (memory full). In the full case, later loader words are not accepted in BOOT.
- **RUN, no patch:**
  - `mem_addr`=`fetch_pc[ADDR_W+1:2]`, `mem_we`=0.
  - `fetch_instr`=`mem_rdata`, `fetch_stall`=0.
- **Fault:** `fetch_fault`=1 when `fetch_pc[1:0]`≠0 or `fetch_pc[31:ADDR_W+2]`≠0.
  - In that case `fetch_instr`=`NOP_INSTR`.
  - Fault is combinational; it is never written to memory and causes no state change.
- **RUN, patch:** with `ld_valid`=1 and the patch feature compiled in, the loader wins the port.
  - `ld_ready`=1, `mem_we`=1, `mem_addr`=`ld_addr[ADDR_W+1:2]`.
  - `fetch_stall`=1 and `fetch_instr`=`NOP_INSTR`.
  - `ld_last` is ignored in RUN.
  - Back-to-back patches stall fetch for every accepted cycle; there is no fairness requirement.
- **`boot_cnt`:** frozen in RUN; it holds the boot count until the next reset.

## Timing
- **Reset values:** state=BOOT, `boot_cnt`=0, `core_rst_n`=0.
  - `ld_ready`=1, `fetch_stall`=1, `fetch_fault`=0, `fetch_instr`=`NOP_INSTR`, `mem_we`=0.
- **Read latency:** zero cycles; `fetch_instr` follows `fetch_pc` combinationally, and memory write data is visible on the cycle after the write.
- **Core release:** `core_rst_n` rises on the first edge after entering RUN, i.e. two edges after the last accepted boot word. The core's first fetch therefore sees every boot word written.
- **Mid-operation reset:** `rst` low in any state or cycle immediately forces the reset values and clears `boot_cnt`. A write in flight at the assertion edge is dropped. Memory contents are not cleared.
- **Patch collisions:**
  - A patch to the address being fetched is the same-cycle collision: fetch stalls, and the next cycle returns the new word.
  - `ld_valid` and a faulting `fetch_pc` in the same cycle: the patch proceeds and `fetch_fault` is still reported.

## Configuration
- `IMEM_CTRL_PATCH_EN` defined: runtime patch writes in RUN as described.
- Undefined: in RUN, `ld_ready`=0, `mem_we` is tied 0 and `fetch_stall`=0. `ld_addr` is unused and `fetch_instr` is always memory data or the NOP on fault.

## Structure
- **Shared package `imem_pkg`:** state enum (BOOT, RUN), the `NOP_INSTR` constant, and the default `ADDR_W`.
- **Sub-module `imem_fetch_guard`:** combinational alignment/range check and NOP substitution, producing `fetch_fault` and the muxed `fetch_instr`.
- **Top level:** FSM, counter and port mux.

## Test plan
- Reset, then load words 0x000002B3, 0x00000333, 0x00628863 with `ld_last` on the third. Expect memory[0..2] written, `boot_cnt`=3, RUN the following edge, `core_rst_n`=1 one edge later, and `fetch_pc`=8 returning 0x00628863.
- Load 1024 words without `ld_last`. Expect RUN after word 1023 and `ld_ready`=0 for one cycle before RUN, i.e. no 1025th write.
- In RUN, `fetch_pc`=0x6 expects `fetch_fault`=1 and `fetch_instr`=0x00000013; `fetch_pc`=0x1000 expects the same fault.
- With the patch feature compiled in, in RUN: `ld_valid`, `ld_addr`=0x8, `ld_data`=0x002083B3 while `fetch_pc`=0x8. Expect `fetch_stall`=1 that cycle and `fetch_instr`=0x002083B3 the next cycle.
- With the patch feature compiled out: same stimulus gives `ld_ready`=0, no write, and `fetch_instr` unchanged.
- Drive `rst` low during the second boot word. Expect `boot_cnt`=0, `core_rst_n`=0 and BOOT state immediately; a reload then restarts at address 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory controller.
package imem_pkg;

  localparam int unsigned ADDR_W_DEF    = 10;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/imem_ctrl_if.sv
// Loader, fetch and memory-port signals of imem_ctrl; slave is the controller side.
interface imem_ctrl_if import imem_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic [31:0]       ld_addr;
  logic              ld_last;

  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_instr;
  logic              fetch_stall;
  logic              fetch_fault;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  ld_valid, ld_data, ld_addr, ld_last, fetch_pc, mem_rdata,
    output ld_ready, fetch_instr, fetch_stall, fetch_fault, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_valid, ld_data, ld_addr, ld_last, fetch_pc, mem_rdata,
    input  ld_ready, fetch_instr, fetch_stall, fetch_fault, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_fetch_guard.sv
// Fetch PC alignment/range check and NOP substitution on the returned instruction.
module imem_fetch_guard import imem_pkg::*; #(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              run,
  input  logic              hold,
  input  logic [31:0]       fetch_pc,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] idx_c,
  output logic              fault_c,
  output logic [31:0]       instr_c
);

  logic misaligned_c;
  logic out_of_range_c;

  assign idx_c          = fetch_pc[ADDR_W+1:2];
  assign misaligned_c   = |fetch_pc[1:0];
  assign out_of_range_c = |fetch_pc[31:ADDR_W+2];

  // Faults are only meaningful once the core is fetching.
  assign fault_c = run & (misaligned_c | out_of_range_c);
  assign instr_c = (hold | fault_c) ? NOP_INSTR : mem_rdata;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: boot loader streaming, core release and fetch port.
// Define IMEM_CTRL_PATCH_EN to let loader writes in RUN preempt fetch (runtime patching).
module imem_ctrl import imem_pkg::*; #(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  imem_ctrl_if.slave        bus,
  output logic              core_rst_n,
  output logic [ADDR_W:0]   boot_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic              boot_done_q, boot_done_d;
  logic [CNT_W-1:0]  boot_cnt_d;

  logic              ld_ready_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic              stall_c;
  logic [ADDR_W-1:0] fetch_idx_c;
  logic              fetch_fault_c;
  logic [31:0]       fetch_instr_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      boot_done_q <= 1'b0;
      boot_cnt    <= '0;
      core_rst_n  <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_done_q <= boot_done_d;
      boot_cnt    <= boot_cnt_d;
      core_rst_n  <= (state_q == ST_RUN);
    end
  end

  // After the final boot word, spend one BOOT cycle with the loader refused before RUN.
  always_comb begin
    state_d     = state_q;
    boot_done_d = boot_done_q;
    boot_cnt_d  = boot_cnt;
    ld_ready_c  = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = fetch_idx_c;
    stall_c     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        stall_c    = 1'b1;
        mem_addr_c = boot_cnt[ADDR_W-1:0];
        if (boot_done_q) begin
          state_d = ST_RUN;
        end else begin
          ld_ready_c = 1'b1;
          if (bus.ld_valid) begin
            mem_we_c   = 1'b1;
            boot_cnt_d = CNT_W'(boot_cnt + 1'b1);
            if (bus.ld_last || (boot_cnt[ADDR_W-1:0] == '1)) begin
              boot_done_d = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
`ifdef IMEM_CTRL_PATCH_EN
        if (bus.ld_valid) begin
          ld_ready_c = 1'b1;
          mem_we_c   = 1'b1;
          stall_c    = 1'b1;
          mem_addr_c = bus.ld_addr[ADDR_W+1:2];
        end
`endif
      end
      default: state_d = ST_BOOT;
    endcase
  end

  imem_fetch_guard #(
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_guard (
    .run       (state_q == ST_RUN),
    .hold      (stall_c),
    .fetch_pc  (bus.fetch_pc),
    .mem_rdata (bus.mem_rdata),
    .idx_c     (fetch_idx_c),
    .fault_c   (fetch_fault_c),
    .instr_c   (fetch_instr_c)
  );

  // Gating with rst drops a write that coincides with reset assertion.
  assign bus.mem_we      = mem_we_c & rst;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = bus.ld_data;
  assign bus.ld_ready    = ld_ready_c;
  assign bus.fetch_stall = stall_c;
  assign bus.fetch_fault = fetch_fault_c;
  assign bus.fetch_instr = fetch_instr_c;

`ifdef IMEM_CTRL_PATCH_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ld_addr[31:ADDR_W+2], bus.ld_addr[1:0]};
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.ld_addr;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized bench for imem_ctrl against a behavioural boot/run model and memory image.
module tb_imem_ctrl;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_CTRL_PATCH_EN
  localparam bit PATCH = 1'b1;
`else
  localparam bit PATCH = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          core_rst_n;
  logic [AW:0]   boot_cnt;

  imem_ctrl_if #(.ADDR_W(AW)) bus ();

  imem_ctrl #(.ADDR_W(AW), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .boot_cnt   (boot_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Memory array seen by the DUT.
  logic [31:0] env_mem [DEPTH];
  bit          env_init;
  assign bus.mem_rdata = env_mem[bus.mem_addr];

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= 32'hC0DE_0000 | 32'(i);
      env_init <= 1'b1;
    end else if (bus.mem_we) begin
      env_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Reference: phase 0 loading, 1 load finished, 2 running.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_init;
  int          m_phase;
  int          m_cnt;
  bit          m_core;

  always @(posedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      ref_init = 1'b1;
    end
    if (!rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_core  = 1'b0;
    end else begin
      m_core = (m_phase == 2);
      if (m_phase == 0) begin
        if (bus.ld_valid) begin
          ref_mem[m_cnt] = bus.ld_data;
          m_cnt++;
          if (bus.ld_last || m_cnt == DEPTH) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (PATCH && bus.ld_valid) begin
        ref_mem[(bus.ld_addr >> 2) % DEPTH] = bus.ld_data;
      end
    end
  end

  bit          e_flt, e_pat;
  logic [31:0] pc;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ld_ready", bus.ld_ready, 1);
      chk("rst_stall", bus.fetch_stall, 1);
      chk("rst_fault", bus.fetch_fault, 0);
      chk("rst_instr", bus.fetch_instr, NOP);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_boot_cnt", boot_cnt, 0);
      chk("rst_core", core_rst_n, 0);
    end else begin
      chk("boot_cnt", boot_cnt, 64'(m_cnt));
      chk("core_rst_n", core_rst_n, m_core);
      if (m_phase == 0) begin
        chk("boot_ready", bus.ld_ready, 1);
        chk("boot_we", bus.mem_we, bus.ld_valid);
        chk("boot_addr", bus.mem_addr, 64'(m_cnt % DEPTH));
        if (bus.ld_valid) chk("boot_wdata", bus.mem_wdata, bus.ld_data);
        chk("boot_stall", bus.fetch_stall, 1);
        chk("boot_fault", bus.fetch_fault, 0);
        chk("boot_instr", bus.fetch_instr, NOP);
      end else if (m_phase == 1) begin
        chk("gap_ready", bus.ld_ready, 0);
        chk("gap_we", bus.mem_we, 0);
        chk("gap_stall", bus.fetch_stall, 1);
        chk("gap_fault", bus.fetch_fault, 0);
        chk("gap_instr", bus.fetch_instr, NOP);
      end else begin
        pc    = bus.fetch_pc;
        e_flt = (pc % 4 != 0) || (pc >= 4 * DEPTH);
        e_pat = PATCH && bus.ld_valid;
        chk("run_ready", bus.ld_ready, e_pat);
        chk("run_we", bus.mem_we, e_pat);
        chk("run_stall", bus.fetch_stall, e_pat);
        chk("run_fault", bus.fetch_fault, e_flt);
        if (e_pat) begin
          chk("patch_addr", bus.mem_addr, 64'((bus.ld_addr >> 2) % DEPTH));
          chk("patch_wdata", bus.mem_wdata, bus.ld_data);
        end else begin
          chk("fetch_addr", bus.mem_addr, 64'((pc >> 2) % DEPTH));
        end
        chk("run_instr", bus.fetch_instr, (e_flt || e_pat) ? NOP : ref_mem[(pc >> 2) % DEPTH]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    step();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic random_run(input int cycles, input bit with_ld);
    for (int k = 0; k < cycles; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      bus.fetch_pc = $urandom;
      else if (r == 1) bus.fetch_pc = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b10};
      else             bus.fetch_pc = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      bus.ld_valid = with_ld && ($urandom_range(0, 3) == 0);
      bus.ld_addr  = $urandom;
      bus.ld_data  = $urandom;
      bus.ld_last  = 1'($urandom);
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_addr  = '0;
    bus.ld_last  = 1'b0;
    bus.fetch_pc = '0;
    repeat (2) step();
    chk("lit_reset_core", core_rst_n, 0);
    chk("lit_reset_instr", bus.fetch_instr, NOP);
    chk("lit_reset_ready", bus.ld_ready, 1);
    rst = 1'b1;

    // Three-word boot with ld_last on the third.
    load_word(32'h0000_02B3, 1'b0);
    load_word(32'h0000_0333, 1'b0);
    load_word(32'h0062_8863, 1'b1);
    chk("lit_boot_cnt3", boot_cnt, 3);
    chk("lit_gap_ready", bus.ld_ready, 0);
    step();
    chk("lit_run_nostall", bus.fetch_stall, 0);
    chk("lit_core_held", core_rst_n, 0);
    step();
    chk("lit_core_released", core_rst_n, 1);
    bus.fetch_pc = 32'h8;
    #1;
    chk("lit_fetch8", bus.fetch_instr, 32'h0062_8863);
    step();
    bus.fetch_pc = 32'h0;
    #1;
    chk("lit_fetch0", bus.fetch_instr, 32'h0000_02B3);
    step();

    // Faulting PCs.
    bus.fetch_pc = 32'h6;
    #1;
    chk("lit_fault6", bus.fetch_fault, 1);
    chk("lit_fault6_instr", bus.fetch_instr, NOP);
    step();
    bus.fetch_pc = 32'h1000;
    #1;
    chk("lit_fault1000", bus.fetch_fault, 1);
    chk("lit_fault1000_instr", bus.fetch_instr, NOP);
    step();

    // Patch colliding with the fetched address.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h8;
    bus.ld_data  = 32'h0020_83B3;
    bus.fetch_pc = 32'h8;
    #1;
`ifdef IMEM_CTRL_PATCH_EN
    chk("lit_patch_stall", bus.fetch_stall, 1);
    chk("lit_patch_instr", bus.fetch_instr, NOP);
    step();
    bus.ld_valid = 1'b0;
    #1;
    chk("lit_patched_word", bus.fetch_instr, 32'h0020_83B3);
`else
    chk("lit_nopatch_ready", bus.ld_ready, 0);
    chk("lit_nopatch_stall", bus.fetch_stall, 0);
    chk("lit_nopatch_we", bus.mem_we, 0);
    step();
    bus.ld_valid = 1'b0;
    #1;
    chk("lit_unpatched_word", bus.fetch_instr, 32'h0062_8863);
`endif
    step();

    random_run(300, 1'b1);

    // Reset during the second boot word, then reload from address 0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    load_word(32'hAAAA_0001, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hBBBB_0002;
    #1;
    rst = 1'b0;
    #1;
    chk("lit_midrst_cnt", boot_cnt, 0);
    chk("lit_midrst_core", core_rst_n, 0);
    chk("lit_midrst_we", bus.mem_we, 0);
    chk("lit_midrst_stall", bus.fetch_stall, 1);
    step();
    bus.ld_valid = 1'b0;
    rst = 1'b1;
    load_word(32'hCCCC_0003, 1'b0);
    chk("lit_reload_cnt1", boot_cnt, 1);
    load_word(32'hDDDD_0004, 1'b0);
    load_word(32'hEEEE_0005, 1'b1);
    repeat (2) step();
    bus.fetch_pc = 32'h0;
    #1;
    chk("lit_reload_addr0", bus.fetch_instr, 32'hCCCC_0003);
    step();
    bus.fetch_pc = 32'h4;
    #1;
    chk("lit_reload_addr1", bus.fetch_instr, 32'hDDDD_0004);
    step();
    random_run(100, 1'b1);

    // Fill the whole memory without ld_last; the loader stays valid past the end.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_last  = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = (i == DEPTH - 1) ? 32'hFEED_F00D : $urandom;
      step();
    end
    chk("lit_full_cnt", boot_cnt, 1024);
    chk("lit_full_ready", bus.ld_ready, 0);
    chk("lit_full_we", bus.mem_we, 0);
    step();
    bus.ld_valid = 1'b0;
    step();
    bus.fetch_pc = 32'hFFC;
    #1;
    chk("lit_full_last", bus.fetch_instr, 32'hFEED_F00D);
    step();
    random_run(200, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
